// File: rtl/ascon_job_arbiter_if.sv
// Requester-side job/response bundle for the shared ascon_core arbiter.
// Requesters drive the master side; the arbiter uses the slave side.
interface ascon_job_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][1:0]   req_mode;
    logic [NUM_REQ-1:0][127:0] req_key;
    logic [NUM_REQ-1:0][127:0] req_nonce;
    logic [NUM_REQ-1:0][127:0] req_ad;
    logic [NUM_REQ-1:0][127:0] req_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [127:0]              rsp_data;
    logic [127:0]              rsp_tag;
    logic                      rsp_error;

    modport master (
        output req_valid, req_mode, req_key, req_nonce, req_ad, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_error
    );

    modport slave (
        input  req_valid, req_mode, req_key, req_nonce, req_ad, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_error
    );
endinterface

// File: rtl/ascon_job_arbiter.sv
// Round-robin arbiter sharing one ascon_core between NUM_REQ requesters:
// operand latching, start pulse, done/timeout watchdog, response handshake.
module ascon_job_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    ascon_job_arbiter_if.slave         host,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       core_start,
    output logic [1:0]                 core_mode,
    output logic [127:0]               core_key,
    output logic [127:0]               core_nonce,
    output logic [127:0]               core_ad,
    output logic [127:0]               core_din,
    input  logic [127:0]               core_ct,
    input  logic [127:0]               core_pt,
    input  logic [127:0]               core_tag,
    input  logic                       core_done,
    input  logic                       core_error
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] winner;
    logic [OW-1:0] rr_next;
    logic          any_valid;
    logic [TW-1:0] timer;

    // Scan from the highest offset down so the requester closest to rr_ptr
    // is the last one written, i.e. the winner.
    always_comb begin
        logic [OW:0]   sum;
        logic [OW-1:0] idx;
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (OW+1)'(k);
            if (sum >= (OW+1)'(NUM_REQ))
                sum = sum - (OW+1)'(NUM_REQ);
            idx = sum[OW-1:0];
            if (host.req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        host.req_ready = '0;
        if (state == IDLE && any_valid && !rst)
            host.req_ready[winner] = 1'b1;
    end

    assign rr_next = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            timer          <= '0;
            core_start     <= 1'b0;
            core_mode      <= '0;
            core_key       <= '0;
            core_nonce     <= '0;
            core_ad        <= '0;
            core_din       <= '0;
            host.rsp_valid <= '0;
            host.rsp_data  <= '0;
            host.rsp_tag   <= '0;
            host.rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner      <= winner;
                        core_mode  <= host.req_mode[winner];
                        core_key   <= host.req_key[winner];
                        core_nonce <= host.req_nonce[winner];
                        core_ad    <= host.req_ad[winner];
                        core_din   <= host.req_data[winner];
                        if (!host.req_mode[winner][1]) begin
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            // Illegal mode: answer with an error without touching the core.
                            host.rsp_valid <= NUM_REQ'(1) << winner;
                            host.rsp_data  <= '0;
                            host.rsp_tag   <= '0;
                            host.rsp_error <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        host.rsp_valid <= NUM_REQ'(1) << owner;
                        host.rsp_data  <= core_mode[0] ? core_pt : core_ct;
                        host.rsp_tag   <= core_tag;
                        host.rsp_error <= core_error;
                        state          <= RESP;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        host.rsp_valid <= NUM_REQ'(1) << owner;
                        host.rsp_data  <= '0;
                        host.rsp_tag   <= '0;
                        host.rsp_error <= 1'b1;
                        state          <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (host.rsp_ready[owner]) begin
                        host.rsp_valid <= '0;
                        rr_ptr         <= rr_next;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_job_arbiter.sv
// Randomized self-checking bench for ascon_job_arbiter with a transaction-level
// reference model (round-robin pointer, expected response per job).
module tb_ascon_job_arbiter;
    localparam int NR = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         busy;
    logic [0:0]   owner;
    logic         core_start;
    logic [1:0]   core_mode;
    logic [127:0] core_key, core_nonce, core_ad, core_din;
    logic [127:0] core_ct, core_pt, core_tag;
    logic         core_done, core_error;

    always #5 clk = ~clk;

    ascon_job_arbiter_if #(.NUM_REQ(NR)) host ();

    ascon_job_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .host(host.slave), .busy(busy), .owner(owner),
        .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
        .core_nonce(core_nonce), .core_ad(core_ad), .core_din(core_din),
        .core_ct(core_ct), .core_pt(core_pt), .core_tag(core_tag),
        .core_done(core_done), .core_error(core_error)
    );

    int n_vec = 0;
    int n_err = 0;
    int rr    = 0;

    logic [127:0] k_v[NR], n_v[NR], a_v[NR], d_v[NR];
    logic [1:0]   m_v[NR];
    logic [127:0] ct_v, pt_v, tag_v;
    logic         err_v;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Spec rule: first valid requester scanning upward from rr, modulo NR.
    function automatic int pick(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++)
            if (mask[(rr + k) % NR]) return (rr + k) % NR;
        return -1;
    endfunction

    task automatic set_mode(input int i, input logic [1:0] m);
        m_v[i]           = m;
        host.req_mode[i] = m;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            k_v[i] = r128(); n_v[i] = r128(); a_v[i] = r128(); d_v[i] = r128();
            host.req_key[i]   = k_v[i];
            host.req_nonce[i] = n_v[i];
            host.req_ad[i]    = a_v[i];
            host.req_data[i]  = d_v[i];
            set_mode(i, ($urandom_range(0, 7) < 6) ? {1'b0, 1'($urandom)} : {1'b1, 1'($urandom)});
        end
    endtask

    task automatic rand_core();
        ct_v = r128(); pt_v = r128(); tag_v = r128(); err_v = 1'($urandom);
    endtask

    // dly: WAIT cycle index at which core_done pulses (-1 = never).
    // hold: cycles rsp_ready for the owner stays low. rst_at: WAIT cycle to reset in (-1 = none).
    task automatic run_job(input logic [NR-1:0] vmask, input int dly, input int hold, input int rst_at);
        int           win;
        logic [1:0]   md;
        logic [127:0] ek, en, ea, ed, exp_d, exp_t;
        logic         exp_e;
        host.req_valid = vmask;
        #1;
        win = pick(vmask);
        chk("busy_idle", busy, 0);
        chk("start_idle", core_start, 0);
        if (win < 0) begin
            chk("rdy_none", host.req_ready, 0);
            step();
            return;
        end
        chk("req_ready", host.req_ready, oh(win));
        md = m_v[win]; ek = k_v[win]; en = n_v[win]; ea = a_v[win]; ed = d_v[win];
        step();
        host.req_valid = NR'($urandom);
        rand_ops();
        #1;
        chk("rdy_busy", host.req_ready, 0);
        chk("owner", owner, win);
        chk("core_start", core_start, !md[1]);
        chk("core_mode", core_mode, md);
        exp_d = '0; exp_t = '0; exp_e = 1'b1;
        if (!md[1]) begin
            chk("core_key", core_key, ek);
            chk("core_nonce", core_nonce, en);
            chk("core_ad", core_ad, ea);
            chk("core_din", core_din, ed);
            step();
            for (int k = 0; k < TO; k++) begin
                host.req_valid = NR'($urandom);
                #1;
                chk("start_wait", core_start, 0);
                chk("rsp_wait", host.rsp_valid, 0);
                chk("rdy_wait", host.req_ready, 0);
                chk("din_hold", core_din, ed);
                if (k == rst_at) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    host.req_valid = '0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_rsp", host.rsp_valid, 0);
                    chk("rst_start", core_start, 0);
                    chk("rst_owner", owner, 0);
                    chk("rst_key", core_key, 0);
                    chk("rst_err", host.rsp_error, 0);
                    chk("rst_rdy", host.req_ready, 0);
                    rr = 0;
                    return;
                end
                if (k == dly) begin
                    core_done = 1'b1; core_ct = ct_v; core_pt = pt_v;
                    core_tag = tag_v; core_error = err_v;
                    step();
                    core_done = 1'b0;
                    exp_d = md[0] ? pt_v : ct_v; exp_t = tag_v; exp_e = err_v;
                    break;
                end
                step();
            end
        end
        for (int h = 0; h <= hold; h++) begin
            host.req_valid = NR'($urandom);
            core_done = 1'($urandom); core_ct = r128(); core_pt = r128(); core_tag = r128();
            host.rsp_ready = (h == hold) ? (NR'($urandom) | oh(win)) : (NR'($urandom) & ~oh(win));
            #1;
            chk("rsp_valid", host.rsp_valid, oh(win));
            chk("rsp_data", host.rsp_data, exp_d);
            chk("rsp_tag", host.rsp_tag, exp_t);
            chk("rsp_error", host.rsp_error, exp_e);
            chk("rdy_resp", host.req_ready, 0);
            chk("busy_resp", busy, 1);
            step();
        end
        host.rsp_ready = '0; core_done = 1'b0; host.req_valid = '0;
        #1;
        chk("busy_done", busy, 0);
        chk("rsp_clear", host.rsp_valid, 0);
        rr = (win + 1) % NR;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        host.req_valid = '0; host.rsp_ready = '0;
        core_done = 1'b0; core_error = 1'b0;
        core_ct = '0; core_pt = '0; core_tag = '0;
        rand_ops();
        rand_core();
        repeat (3) step();
        host.req_valid = '1;
        #1;
        chk("rst_rdy_gate", host.req_ready, 0);
        host.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rsp", host.rsp_valid, 0);
        chk("reset_start", core_start, 0);
        chk("reset_owner", owner, 0);
        chk("reset_key", core_key, 0);
        chk("reset_data", host.rsp_data, 0);

        // Encrypt job with known core results
        set_mode(0, 2'b00);
        ct_v = {4{32'hA5A5A5A5}}; tag_v = {4{32'h5A5A5A5A}}; err_v = 1'b0; pt_v = r128();
        run_job(2'b01, 2, 1, -1);

        // Simultaneous requests alternate
        for (int j = 0; j < 4; j++) begin
            set_mode(0, 2'b01); set_mode(1, 2'b00); rand_core();
            run_job(2'b11, j, 0, -1);
        end

        // Illegal mode from req1
        set_mode(1, 2'b10);
        run_job(2'b10, 0, 0, -1);

        // Timeout, then a stray done in IDLE
        set_mode(0, 2'b00);
        run_job(2'b01, -1, 0, -1);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        #1;
        chk("late_done_busy", busy, 0);
        chk("late_done_rsp", host.rsp_valid, 0);

        // Done on the last WAIT cycle wins over timeout
        set_mode(1, 2'b01); rand_core();
        run_job(2'b10, TO - 1, 0, -1);

        // Long response stall, then req1 right after handshake
        set_mode(0, 2'b00); rand_core();
        run_job(2'b01, 3, 20, -1);
        set_mode(1, 2'b00); rand_core();
        run_job(2'b10, 1, 0, -1);

        // Reset mid-job, then rr_ptr must be back at 0
        set_mode(0, 2'b00); set_mode(1, 2'b00);
        run_job(2'b11, -1, 0, 3);
        set_mode(0, 2'b00); set_mode(1, 2'b00); rand_core();
        run_job(2'b11, 0, 0, -1);

        for (int j = 0; j < 60; j++) begin
            rand_core();
            run_job(NR'($urandom), ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
                    int'($urandom_range(0, 4)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
